mult_issue_buf: RTL and testbench

Multiply issue buffer sitting directly upstream of the radix-4 Booth multiplier in the execute stage. Queues dispatched multiply operations (two 16-bit operands plus destination tag), issues them one at a time to the multiplier, captures the one-cycle result pulse, and holds tag and result for the writeback/CDB arbiter until acknowledged. Supports pipeline flush, including squash of an operation already inside the multiplier.

---
 rtl/mult_issue_buf_if.sv | 44 ++++
 rtl/mult_issue_buf.sv | 140 ++++++++++++++
 tb/tb_mult_issue_buf.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_issue_buf_if.sv
// ============================================================================
// mult_issue_buf_if : dispatch, multiplier and writeback signal bundle for
//                     the multiply issue buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mult_issue_buf_if #(
  parameter int TAG_W = 6
);
  logic             alloc_en;
  logic [15:0]      alloc_op1;
  logic [15:0]      alloc_op2;
  logic [TAG_W-1:0] alloc_tag;
  logic             rs_full;
  logic             rs_empty;
  logic             flush;
  logic             mult_en;
  logic [15:0]      mult_op1;
  logic [15:0]      mult_op2;
  logic             mult_valid_wb;
  logic [15:0]      mult_out;
  logic             wb_valid;
  logic [15:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ack;

  // Environment side: dispatch, multiplier and writeback arbiter.
  modport master (
    output alloc_en, alloc_op1, alloc_op2, alloc_tag, flush,
    output mult_valid_wb, mult_out, wb_ack,
    input  rs_full, rs_empty, mult_en, mult_op1, mult_op2,
    input  wb_valid, wb_data, wb_tag
  );

  modport slave (
    input  alloc_en, alloc_op1, alloc_op2, alloc_tag, flush,
    input  mult_valid_wb, mult_out, wb_ack,
    output rs_full, rs_empty, mult_en, mult_op1, mult_op2,
    output wb_valid, wb_data, wb_tag
  );
endinterface

`default_nettype wire

// File: rtl/mult_issue_buf.sv
// ============================================================================
// mult_issue_buf : FIFO of multiply ops feeding one Booth multiplier, with
//                  result hold for writeback and flush/squash support.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_issue_buf #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_issue_buf_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]       r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_squash;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_wb_data;
  logic [TAG_W-1:0] r_wb_tag;

  logic [15:0]      r_op1_mem [DEPTH];
  logic [15:0]      r_op2_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !bus.flush;
  // A pop on the same edge frees the slot, so a write while full is safe then.
  assign w_push  = bus.alloc_en && !bus.flush && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_op1_mem[i] <= '0;
        r_op2_mem[i] <= '0;
        r_tag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_op1_mem[r_wr_ptr] <= bus.alloc_op1;
      r_op2_mem[r_wr_ptr] <= bus.alloc_op2;
      r_tag_mem[r_wr_ptr] <= bus.alloc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_squash  <= 1'b0;
      r_tag     <= '0;
      r_wb_data <= '0;
      r_wb_tag  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tag   <= r_tag_mem[r_rd_ptr];
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // The multiplier cannot be aborted: a flushed op waits out its pulse.
          if (bus.mult_valid_wb) begin
            if (r_squash || bus.flush) begin
              r_squash <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_wb_data <= bus.mult_out;
              r_wb_tag  <= r_tag;
              r_state   <= S_WB;
            end
          end else if (bus.flush) begin
            r_squash <= 1'b1;
          end
        end
        S_WB: begin
          if (bus.flush || bus.wb_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_squash <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rs_full  = w_full;
  assign bus.rs_empty = w_empty;
  assign bus.mult_en  = w_pop;
  assign bus.mult_op1 = r_op1_mem[r_rd_ptr];
  assign bus.mult_op2 = r_op2_mem[r_rd_ptr];
  assign bus.wb_valid = (r_state == S_WB);
  assign bus.wb_data  = r_wb_data;
  assign bus.wb_tag   = r_wb_tag;

endmodule

`default_nettype wire

// File: tb/tb_mult_issue_buf.sv
// ============================================================================
// tb_mult_issue_buf : directed bench with a 9-cycle multiplier model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_issue_buf;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mult_issue_buf_if #(.TAG_W(6)) bus ();

  mult_issue_buf #(.DEPTH(4), .TAG_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: samples on issue, pulses the product 8 edges later.
  logic        mb_busy;
  logic [3:0]  mb_cnt;
  logic [15:0] mb_a;
  logic [15:0] mb_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_busy           <= 1'b0;
      mb_cnt            <= '0;
      mb_a              <= '0;
      mb_b              <= '0;
      bus.mult_valid_wb <= 1'b0;
      bus.mult_out      <= '0;
    end else if (bus.mult_valid_wb) begin
      bus.mult_valid_wb <= 1'b0;
      bus.mult_out      <= 16'hDEAD;
      mb_busy           <= 1'b0;
    end else if (mb_busy) begin
      if (mb_cnt == 4'd1) begin
        bus.mult_valid_wb <= 1'b1;
        bus.mult_out      <= 16'(mb_a * mb_b);
      end else begin
        mb_cnt <= mb_cnt - 4'd1;
      end
    end else if (bus.mult_en) begin
      mb_busy <= 1'b1;
      mb_cnt  <= 4'd8;
      mb_a    <= bus.mult_op1;
      mb_b    <= bus.mult_op2;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.mult_en) begin
      checks++;
      if (mb_busy) begin
        errors++;
        $display("FAIL issue_while_busy: mult_en=1 while multiplier busy at %0t", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wb(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.wb_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alloc_en = 0; bus.alloc_op1 = 0; bus.alloc_op2 = 0; bus.alloc_tag = 0;
    bus.flush = 0; bus.wb_ack = 0;
    #2;
    checks++; if (bus.rs_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", bus.rs_empty); end
    checks++; if (bus.rs_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", bus.rs_full); end
    checks++; if (bus.mult_en !== 1'b0) begin errors++; $display("FAIL rst_mult_en: got %b exp 0", bus.mult_en); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", bus.wb_valid); end
    checks++; if (bus.wb_data !== 16'h0 || bus.wb_tag !== 6'd0) begin errors++; $display("FAIL rst_wb: got %h/%0d exp 0/0", bus.wb_data, bus.wb_tag); end
    checks++; if (bus.mult_op1 !== 16'h0 || bus.mult_op2 !== 16'h0) begin errors++; $display("FAIL rst_ops: got %h/%h exp 0/0", bus.mult_op1, bus.mult_op2); end
    cyc(2);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bus.alloc_en = 1; bus.alloc_op1 = 16'h0007; bus.alloc_op2 = 16'h0006; bus.alloc_tag = 6'd5;
    #1;
    checks++; if (bus.mult_en !== 1'b0) begin errors++; $display("FAIL single_no_comb: mult_en got %b exp 0", bus.mult_en); end
    cyc();
    bus.alloc_en = 0;
    #1;
    checks++; if (bus.mult_en !== 1'b1) begin errors++; $display("FAIL single_issue: mult_en got %b exp 1", bus.mult_en); end
    checks++; if (bus.mult_op1 !== 16'h7 || bus.mult_op2 !== 16'h6) begin errors++; $display("FAIL single_ops: got %h/%h exp 0007/0006", bus.mult_op1, bus.mult_op2); end
    cyc(9);
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_early_wb: got %b exp 0", bus.wb_valid); end
    cyc();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 16'h002A || bus.wb_tag !== 6'd5) begin errors++; $display("FAIL single_wb: got %h/%0d exp 002a/5", bus.wb_data, bus.wb_tag); end
    cyc(3);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h002A || bus.wb_tag !== 6'd5) begin errors++; $display("FAIL single_hold: got %b %h/%0d exp 1 002a/5", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    bus.wb_ack = 1;
    cyc();
    bus.wb_ack = 0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.mult_en !== 1'b0) begin errors++; $display("FAIL single_ack: wb_valid/mult_en got %b/%b exp 0/0", bus.wb_valid, bus.mult_en); end
  endtask

  task automatic test_back_to_back();
    bus.alloc_en = 1; bus.alloc_op1 = 16'hFFFD; bus.alloc_op2 = 16'h0004; bus.alloc_tag = 6'd1;
    cyc();
    bus.alloc_op1 = 16'h0100; bus.alloc_op2 = 16'h0100; bus.alloc_tag = 6'd2;
    #1;
    checks++; if (bus.mult_en !== 1'b1 || bus.mult_op1 !== 16'hFFFD) begin errors++; $display("FAIL b2b_issue1: got %b/%h exp 1/fffd", bus.mult_en, bus.mult_op1); end
    cyc();
    bus.alloc_en = 0; bus.wb_ack = 1;
    cyc(9);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'hFFF4 || bus.wb_tag !== 6'd1) begin errors++; $display("FAIL b2b_res1: got %b %h/%0d exp 1 fff4/1", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    checks++; if (bus.mult_en !== 1'b0) begin errors++; $display("FAIL b2b_no_issue_in_wb: got %b exp 0", bus.mult_en); end
    cyc();
    checks++; if (bus.mult_en !== 1'b1 || bus.mult_op1 !== 16'h0100 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue2: got %b/%h/%b exp 1/0100/0", bus.mult_en, bus.mult_op1, bus.wb_valid); end
    cyc(10);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h0000 || bus.wb_tag !== 6'd2) begin errors++; $display("FAIL b2b_res2: got %b %h/%0d exp 1 0000/2", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    cyc();
    checks++; if (bus.wb_valid !== 1'b0 || bus.rs_empty !== 1'b1) begin errors++; $display("FAIL b2b_done: wb_valid/empty got %b/%b exp 0/1", bus.wb_valid, bus.rs_empty); end
    bus.wb_ack = 0;
  endtask

  task automatic test_full_wrap();
    int         n;
    logic [5:0] got_tag [8];
    logic [15:0] got_dat [8];
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.alloc_en = 1; bus.alloc_op1 = 16'(10 + i); bus.alloc_op2 = 16'd2; bus.alloc_tag = 6'(10 + i);
      #1;
      if (i == 4) begin
        checks++; if (bus.rs_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b exp 0", bus.rs_full); end
      end
      if (i == 5) begin
        checks++; if (bus.rs_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b exp 1", bus.rs_full); end
      end
      cyc();
    end
    bus.alloc_en = 0;
    #1;
    checks++; if (bus.rs_full !== 1'b1) begin errors++; $display("FAIL full_extra_ignored: rs_full got %b exp 1", bus.rs_full); end
    bus.wb_ack = 1;
    for (int c = 0; c < 80; c++) begin
      if (bus.wb_valid) begin
        if (n < 8) begin
          got_tag[n] = bus.wb_tag;
          got_dat[n] = bus.wb_data;
        end
        n++;
      end
      cyc();
    end
    bus.wb_ack = 0;
    checks++; if (n !== 5) begin errors++; $display("FAIL full_retire_count: got %0d exp 5", n); end
    for (int k = 0; k < 5 && k < n; k++) begin
      checks++;
      if (got_tag[k] !== 6'(10 + k) || got_dat[k] !== 16'(2 * (10 + k))) begin
        errors++;
        $display("FAIL full_order[%0d]: got %0d/%h exp %0d/%h", k, got_tag[k], got_dat[k], 10 + k, 2 * (10 + k));
      end
    end
    checks++; if (bus.rs_empty !== 1'b1) begin errors++; $display("FAIL full_drained: rs_empty got %b exp 1", bus.rs_empty); end
  endtask

  task automatic test_flush_busy();
    bit ok;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_en = 1; bus.alloc_op1 = 16'(i + 1); bus.alloc_op2 = 16'd1; bus.alloc_tag = 6'(20 + i);
      cyc();
    end
    bus.alloc_en = 0;
    cyc();
    bus.flush = 1;
    #1;
    checks++; if (bus.mult_en !== 1'b0) begin errors++; $display("FAIL fbusy_gate: mult_en got %b exp 0", bus.mult_en); end
    cyc();
    bus.flush = 0;
    #1;
    checks++; if (bus.rs_empty !== 1'b1 || bus.mult_en !== 1'b0) begin errors++; $display("FAIL fbusy_cleared: empty/mult_en got %b/%b exp 1/0", bus.rs_empty, bus.mult_en); end
    for (int c = 0; c < 15; c++) begin
      if (bus.wb_valid || bus.mult_en) seen = 1'b1;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fbusy_squash: got activity %b exp 0", seen); end
    bus.alloc_en = 1; bus.alloc_op1 = 16'd3; bus.alloc_op2 = 16'd3; bus.alloc_tag = 6'd9;
    cyc();
    bus.alloc_en = 0;
    wait_wb(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fbusy_timeout: wb_valid got 0 exp 1"); end
    checks++; if (bus.wb_data !== 16'h0009 || bus.wb_tag !== 6'd9) begin errors++; $display("FAIL fbusy_new_op: got %h/%0d exp 0009/9", bus.wb_data, bus.wb_tag); end
    bus.wb_ack = 1;
    cyc();
    bus.wb_ack = 0;
  endtask

  task automatic test_flush_edges();
    bit ok;
    bus.alloc_en = 1; bus.flush = 1; bus.alloc_op1 = 16'd1; bus.alloc_op2 = 16'd1; bus.alloc_tag = 6'd30;
    cyc();
    bus.alloc_en = 0; bus.flush = 0;
    #1;
    checks++; if (bus.rs_empty !== 1'b1 || bus.mult_en !== 1'b0) begin errors++; $display("FAIL fedge_alloc_drop: empty/mult_en got %b/%b exp 1/0", bus.rs_empty, bus.mult_en); end
    bus.alloc_en = 1; bus.alloc_op1 = 16'd5; bus.alloc_op2 = 16'd5; bus.alloc_tag = 6'd31;
    cyc();
    bus.alloc_en = 0;
    cyc(9);
    bus.flush = 1;
    cyc();
    bus.flush = 0;
    bus.alloc_en = 1; bus.alloc_op1 = 16'd2; bus.alloc_op2 = 16'd3; bus.alloc_tag = 6'd32;
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fedge_pulse_discard: wb_valid got %b exp 0", bus.wb_valid); end
    cyc();
    bus.alloc_en = 0;
    #1;
    checks++; if (bus.mult_en !== 1'b1) begin errors++; $display("FAIL fedge_back_idle: mult_en got %b exp 1", bus.mult_en); end
    wait_wb(30, ok);
    checks++; if (!ok || bus.wb_data !== 16'h0006 || bus.wb_tag !== 6'd32) begin errors++; $display("FAIL fedge_next_op: got %b %h/%0d exp 1 0006/32", ok, bus.wb_data, bus.wb_tag); end
    bus.flush = 1; bus.wb_ack = 1;
    cyc();
    bus.flush = 0; bus.wb_ack = 0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.rs_empty !== 1'b1) begin errors++; $display("FAIL fedge_wb_flush: wb_valid/empty got %b/%b exp 0/1", bus.wb_valid, bus.rs_empty); end
    cyc(3);
    checks++; if (bus.wb_valid !== 1'b0 || bus.mult_en !== 1'b0) begin errors++; $display("FAIL fedge_no_double: wb_valid/mult_en got %b/%b exp 0/0", bus.wb_valid, bus.mult_en); end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_en = 1; bus.alloc_op1 = 16'd1; bus.alloc_op2 = 16'd1; bus.alloc_tag = 6'(40 + i);
      cyc();
    end
    bus.alloc_en = 0;
    #1;
    checks++; if (bus.rs_empty !== 1'b0) begin errors++; $display("FAIL arst_pre_queue: empty got %b exp 0", bus.rs_empty); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rs_empty !== 1'b1 || bus.rs_full !== 1'b0 || bus.mult_en !== 1'b0) begin errors++; $display("FAIL arst_flags: empty/full/mult_en got %b/%b/%b exp 1/0/0", bus.rs_empty, bus.rs_full, bus.mult_en); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 16'h0 || bus.wb_tag !== 6'd0) begin errors++; $display("FAIL arst_wb: got %b %h/%0d exp 0 0000/0", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    checks++; if (bus.mult_op1 !== 16'h0 || bus.mult_op2 !== 16'h0) begin errors++; $display("FAIL arst_ops: got %h/%h exp 0/0", bus.mult_op1, bus.mult_op2); end
    cyc(2);
    rst_n = 1'b1;
    cyc();
    bus.alloc_en = 1; bus.alloc_op1 = 16'd4; bus.alloc_op2 = 16'd4; bus.alloc_tag = 6'd7;
    cyc();
    bus.alloc_en = 0;
    #1;
    checks++; if (bus.mult_en !== 1'b1) begin errors++; $display("FAIL arst_reissue: mult_en got %b exp 1", bus.mult_en); end
    wait_wb(30, ok);
    checks++; if (!ok || bus.wb_data !== 16'h0010 || bus.wb_tag !== 6'd7) begin errors++; $display("FAIL arst_result: got %b %h/%0d exp 1 0010/7", ok, bus.wb_data, bus.wb_tag); end
    bus.wb_ack = 1;
    cyc();
    bus.wb_ack = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_flush_busy();
    test_flush_edges();
    test_async_reset();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
